// File: rtl/phase_programmer_tx.sv
// rtl/phase_programmer_tx.sv - phase-programming link transmitter
// Queues host nibbles and sends each one as a GIVE/CONFIRM pair, then closes the phase with END.
module phase_programmer_tx #(
  parameter int DEPTH   = 8,
  parameter int PHASE_W = 3,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [3:0]         wr_data,
  output logic               full,
  input  logic               start,
  input  logic               phaser_plus,
  output logic               in1,
  output logic               in2,
  output logic [3:0]         data,
  output logic [PHASE_W-1:0] phaser,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GIVE, S_CONFIRM, S_END} state_t;

  state_t               state_q, state_d;
  logic [3:0]           mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TW-1:0]        wait_q, wait_d;
  logic [PHASE_W-1:0]   phaser_q, phaser_d;
  logic                 in1_q, in1_d;
  logic                 in2_q, in2_d;
  logic [3:0]           data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 full_q, full_d;

  logic                 wr_acc;
  logic                 avail;
  logic                 pop;
  logic                 store;
  logic                 deq;
  logic [3:0]           head;

  always_comb begin
    wr_acc   = wr_en & ~full_q;
    // A nibble written in the same cycle as a pop decision is visible to it (bypass).
    avail    = (count_q != '0) | wr_acc;
    head     = (count_q != '0) ? mem_q[rd_ptr_q] : wr_data;
    pop      = 1'b0;
    state_d  = state_q;
    wait_d   = wait_q;
    phaser_d = phaser_q;
    err_d    = err_q;
    done_d   = 1'b0;
    data_d   = data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (avail) begin
            state_d = S_GIVE;
            pop     = 1'b1;
            data_d  = head;
          end else begin
            state_d = S_END;
            wait_d  = '0;
            data_d  = 4'h0;
          end
        end
      end
      S_GIVE: begin
        state_d = S_CONFIRM;
      end
      S_CONFIRM: begin
        if (avail) begin
          state_d = S_GIVE;
          pop     = 1'b1;
          data_d  = head;
        end else begin
          state_d = S_END;
          wait_d  = '0;
          data_d  = 4'h0;
        end
      end
      S_END: begin
        if (phaser_plus) begin
          phaser_d = phaser_q + PHASE_W'(1);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        data_d  = 4'h0;
      end
    endcase

    // When the FIFO is empty a simultaneous write and pop passes straight through.
    store    = wr_acc & ~(pop & (count_q == '0));
    deq      = pop & (count_q != '0);
    wr_ptr_d = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(store) - CW'(deq);
    full_d   = (count_d == CW'(DEPTH));

    in1_d  = (state_d == S_IDLE) | (state_d == S_GIVE);
    in2_d  = (state_d == S_GIVE) | (state_d == S_CONFIRM);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      phaser_q <= '0;
      in1_q    <= 1'b1;
      in2_q    <= 1'b0;
      data_q   <= 4'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      phaser_q <= phaser_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      full_q   <= full_d;
    end
  end

  assign in1    = in1_q;
  assign in2    = in2_q;
  assign data   = data_q;
  assign phaser = phaser_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign full   = full_q;

endmodule
